// File: rtl/game_pkg.sv
// Shared constants for the game tick scheduler:
// slot ids, controller bit positions and FSM states.
package game_pkg;

   localparam int SLOT_PLAYER = 0;
   localparam int SLOT_DRAGON = 1;
   localparam int SLOT_SHEEP  = 2;

   localparam int BTN_A      = 7;
   localparam int BTN_B      = 6;
   localparam int BTN_SELECT = 5;
   localparam int BTN_START  = 4;
   localparam int BTN_UP     = 3;
   localparam int BTN_DOWN   = 2;
   localparam int BTN_LEFT   = 1;
   localparam int BTN_RIGHT  = 0;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LATCH  = 2'd1,
      ST_SELECT = 2'd2,
      ST_WAIT   = 2'd3
   } state_e;

endpackage

// File: rtl/game_tick_scheduler_if.sv
// Update-slot grant/done bundle between the scheduler
// and the entity controllers.
interface game_tick_scheduler_if #(
   parameter int N_SLOTS = 3
);

   logic [N_SLOTS-1:0] grant;
   logic [N_SLOTS-1:0] done;

   modport master (output grant, input done);
   modport slave  (input grant, output done);

endinterface

// File: rtl/game_tick_scheduler_tick_divider.sv
// Divides the frame_start pulse train down to a
// one-cycle tick_due pulse every FRAMES_PER_TICK frames.
module tick_divider #(
   parameter int FRAMES_PER_TICK = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic frame_start_i,
   output logic tick_due_o
);

   localparam int FW = $clog2(FRAMES_PER_TICK) + 1;
   localparam logic [FW-1:0] LAST = FW'(FRAMES_PER_TICK - 1);

   logic [FW-1:0] fcnt_q;
   logic [FW-1:0] fcnt_d;

   assign tick_due_o = frame_start_i && (fcnt_q == LAST);

   always_comb begin
      fcnt_d = fcnt_q;
      if (frame_start_i) begin
         fcnt_d = tick_due_o ? '0 : fcnt_q + FW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fcnt_q <= '0;
      end else begin
         fcnt_q <= fcnt_d;
      end
   end

endmodule

// File: rtl/game_tick_scheduler.sv
// Per-tick update sequencer: snapshots buttons, then grants
// each enabled slot in order until done or timeout.
module game_tick_scheduler
   import game_pkg::*;
#(
   parameter int N_SLOTS         = 3,
   parameter int FRAMES_PER_TICK = 8,
   parameter int TIMEOUT         = 15,
   parameter int BTN_W           = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 frame_start,
   input  logic [BTN_W-1:0]     buttons,
   input  logic [N_SLOTS-1:0]   slot_en,
   input  logic                 err_clr,
   game_tick_scheduler_if.master upd,
   output logic [BTN_W-1:0]     btn_latched,
   output logic                 tick,
   output logic                 busy,
   output logic                 overrun,
   output logic                 timeout_err
);

   localparam int IW = $clog2(N_SLOTS + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

   state_e             state_q;
   logic [IW-1:0]      idx_q;
   logic [TW-1:0]      wcnt_q;
   logic [N_SLOTS-1:0] en_q;
   logic [N_SLOTS-1:0] grant_q;
   logic [BTN_W-1:0]   btn_q;
   logic               tick_q;
   logic               busy_q;
   logic               ovr_q;
   logic               tmo_q;

   logic               tick_due;
   logic [IW-1:0]      base;
   logic [N_SLOTS-1:0] cand_en;
   logic               found;
   logic [IW-1:0]      fidx;
   logic               done_hit;
   logic               tmo_hit;
   logic               ovr_set;

   tick_divider #(
      .FRAMES_PER_TICK (FRAMES_PER_TICK)
   ) u_div (
      .clk           (clk),
      .rst_n         (rst_n),
      .frame_start_i (frame_start),
      .tick_due_o    (tick_due)
   );

   // LATCH searches the live enables since en_q loads on the same edge
   always_comb begin
      base    = (state_q == ST_LATCH) ? IW'(SLOT_PLAYER) : idx_q;
      cand_en = (state_q == ST_LATCH) ? slot_en : en_q;
      found   = 1'b0;
      fidx    = '0;
      for (int i = 0; i < N_SLOTS; i++) begin
         if (!found && cand_en[i] && (IW'(i) >= base)) begin
            found = 1'b1;
            fidx  = IW'(i);
         end
      end
   end

   assign done_hit = |(upd.done & grant_q);
   assign tmo_hit  = (state_q == ST_WAIT) && !done_hit
                     && (wcnt_q == T_LAST);
   assign ovr_set  = tick_due && (state_q != ST_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         wcnt_q  <= '0;
         en_q    <= '0;
         grant_q <= '0;
         btn_q   <= '0;
         tick_q  <= 1'b0;
         busy_q  <= 1'b0;
         ovr_q   <= 1'b0;
         tmo_q   <= 1'b0;
      end else begin
         tick_q <= 1'b0;
         ovr_q  <= ovr_set | (ovr_q & ~err_clr);
         tmo_q  <= tmo_hit | (tmo_q & ~err_clr);
         unique case (state_q)
            ST_IDLE: begin
               if (tick_due) begin
                  state_q <= ST_LATCH;
                  tick_q  <= 1'b1;
                  busy_q  <= 1'b1;
               end
            end
            ST_LATCH, ST_SELECT: begin
               if (state_q == ST_LATCH) begin
                  btn_q <= buttons;
                  en_q  <= slot_en;
               end
               wcnt_q <= '0;
               if (found) begin
                  state_q <= ST_WAIT;
                  idx_q   <= fidx;
                  grant_q <= N_SLOTS'(1) << fidx;
               end else begin
                  state_q <= ST_IDLE;
                  idx_q   <= '0;
                  busy_q  <= 1'b0;
               end
            end
            ST_WAIT: begin
               if (done_hit || (wcnt_q == T_LAST)) begin
                  state_q <= ST_SELECT;
                  grant_q <= '0;
                  idx_q   <= idx_q + IW'(1);
                  wcnt_q  <= '0;
               end else begin
                  wcnt_q <= wcnt_q + TW'(1);
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign upd.grant   = grant_q;
   assign btn_latched = btn_q;
   assign tick        = tick_q;
   assign busy        = busy_q;
   assign overrun     = ovr_q;
   assign timeout_err = tmo_q;

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Directed bench for game_tick_scheduler: divide, sequencing,
// skip, timeout, overrun and async reset.
module tb_game_tick_scheduler;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       frame_start;
   logic [7:0] buttons;
   logic [2:0] slot_en;
   logic       err_clr;
   logic [7:0] btn_latched;
   logic       tick, busy, overrun, timeout_err;

   logic       frame5;
   logic [7:0] buttons5;
   logic [2:0] slot_en5;
   logic [7:0] btn5;
   logic       tick5, busy5, ovr5, tmo5;

   int         n_chk = 0;
   int         n_err = 0;
   int         dly = 0;
   logic [2:0] hang = '0;
   logic [2:0] prev_g = '0;
   int         age = 0;
   int         extra;
   logic [6:0] q[$];

   always #5 clk = ~clk;

   game_tick_scheduler_if #(.N_SLOTS(3)) upd ();
   game_tick_scheduler_if #(.N_SLOTS(3)) upd5 ();

   game_tick_scheduler #(
      .N_SLOTS(3), .FRAMES_PER_TICK(8), .TIMEOUT(15), .BTN_W(8)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .frame_start (frame_start),
      .buttons     (buttons),
      .slot_en     (slot_en),
      .err_clr     (err_clr),
      .upd         (upd),
      .btn_latched (btn_latched),
      .tick        (tick),
      .busy        (busy),
      .overrun     (overrun),
      .timeout_err (timeout_err)
   );

   game_tick_scheduler #(
      .N_SLOTS(3), .FRAMES_PER_TICK(1), .TIMEOUT(15), .BTN_W(8)
   ) dut5 (
      .clk         (clk),
      .rst_n       (rst_n),
      .frame_start (frame5),
      .buttons     (buttons5),
      .slot_en     (slot_en5),
      .err_clr     (1'b0),
      .upd         (upd5),
      .btn_latched (btn5),
      .tick        (tick5),
      .busy        (busy5),
      .overrun     (ovr5),
      .timeout_err (tmo5)
   );

   assign upd5.done = '0;

   // slot owners: done after dly cycles; hung slot raises stray bits
   always @(negedge clk) begin
      if (upd.grant != 3'b000 && upd.grant == prev_g) age++;
      else age = 0;
      prev_g = upd.grant;
      if ((upd.grant & hang) != 3'b000) upd.done = ~upd.grant;
      else if (upd.grant != 3'b000 && age == dly) upd.done = upd.grant;
      else upd.done = 3'b000;
   end

   function automatic logic [6:0] snap();
      return {overrun, timeout_err, tick, busy, upd.grant};
   endfunction

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic add(input logic [6:0] v, input int n);
      repeat (n) q.push_back(v);
   endtask

   task automatic frames(input int n);
      repeat (n) begin
         @(negedge clk) frame_start = 1'b1;
         @(negedge clk) frame_start = 1'b0;
         repeat (3) @(negedge clk);
      end
   endtask

   // tick-due pulse, then compare {ovr,tmo,tick,busy,grant} per cycle
   task automatic trace(input string tag, input logic [7:0] btn_mid,
                        input logic [7:0] btn_exp);
      @(negedge clk) frame_start = 1'b1;
      foreach (q[k]) begin
         @(negedge clk);
         frame_start = 1'b0;
         check($sformatf("%s[%0d]", tag, k + 1), 32'(snap()), 32'(q[k]));
         if (k == 5) buttons = btn_mid;
      end
      check({tag, "_btn"}, 32'(btn_latched), 32'(btn_exp));
   endtask

   initial begin
      rst_n = 1'b0; frame_start = 1'b0; buttons = 8'h00;
      slot_en = 3'b111; err_clr = 1'b0;
      frame5 = 1'b0; buttons5 = 8'h00; slot_en5 = 3'b001;
      repeat (3) @(negedge clk);
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      check("rst_out", 32'(snap()), 32'h0);
      check("rst_btn", 32'(btn_latched), 32'h0);
      check("rst_tick5", 32'({tick5, busy5, ovr5, upd5.grant}), 32'h0);
      @(negedge clk) rst_n = 1'b1;

      // T1: divide by 8
      dly = 0; extra = 0;
      for (int p = 1; p <= 16; p++) begin
         @(negedge clk) frame_start = 1'b1;
         @(negedge clk) frame_start = 1'b0;
         check($sformatf("t1_tick%0d", p), 32'(tick), 32'(p % 8 == 0));
         repeat (8) begin
            @(negedge clk);
            if (tick) extra++;
         end
      end
      check("t1_extra", 32'(extra), 32'd0);

      // T2: sequencing with 4-cycle grants
      dly = 3; buttons = 8'h88;
      frames(7);
      q.delete();
      add(7'h18, 1); add(7'h09, 4); add(7'h08, 1); add(7'h0A, 4);
      add(7'h08, 1); add(7'h0C, 4); add(7'h08, 1); add(7'h00, 1);
      trace("t2", 8'h01, 8'h88);

      // T3: skip slot 1
      dly = 1; slot_en = 3'b101;
      frames(7);
      q.delete();
      add(7'h18, 1); add(7'h09, 2); add(7'h08, 1);
      add(7'h0C, 2); add(7'h08, 1); add(7'h00, 1);
      trace("t3", 8'h01, 8'h01);

      slot_en = 3'b000;
      frames(7);
      q.delete();
      add(7'h18, 1); add(7'h00, 2);
      trace("t3b", 8'h01, 8'h01);

      // T4: slot 1 hangs
      dly = 0; hang = 3'b010; slot_en = 3'b111; buttons = 8'h3C;
      frames(7);
      q.delete();
      add(7'h18, 1); add(7'h09, 1); add(7'h08, 1); add(7'h0A, 15);
      add(7'h28, 1); add(7'h2C, 1); add(7'h28, 1); add(7'h20, 1);
      trace("t4", 8'h3C, 8'h3C);
      hang = 3'b000;
      @(negedge clk) err_clr = 1'b1;
      @(negedge clk) err_clr = 1'b0;
      check("t4_clr", 32'(snap()), 32'h0);

      // done on the timeout cycle wins
      dly = 14; slot_en = 3'b010;
      frames(7);
      q.delete();
      add(7'h18, 1); add(7'h0A, 15); add(7'h08, 1); add(7'h00, 1);
      trace("t7", 8'h3C, 8'h3C);

      // T5: overrun on the divide-by-1 instance
      buttons5 = 8'h5A;
      @(negedge clk) frame5 = 1'b1;
      @(negedge clk) frame5 = 1'b0;
      check("t5_tick", 32'(tick5), 32'd1);
      @(negedge clk);
      check("t5_grant", 32'(upd5.grant), 32'h1);
      check("t5_btn", 32'(btn5), 32'h5A);
      buttons5 = 8'hFF; frame5 = 1'b1;
      @(negedge clk) frame5 = 1'b0;
      check("t5_notick", 32'(tick5), 32'd0);
      check("t5_ovr", 32'(ovr5), 32'd1);
      @(negedge clk);
      check("t5_btn2", 32'(btn5), 32'h5A);
      check("t5_notick2", 32'(tick5), 32'd0);

      // T6: async reset while slot 1 holds the grant
      dly = 3; slot_en = 3'b111;
      frames(7);
      @(negedge clk) frame_start = 1'b1;
      @(negedge clk) frame_start = 1'b0;
      repeat (6) @(negedge clk);
      check("t6_pre", 32'(upd.grant), 32'h2);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("t6_async", 32'(snap()), 32'h0);
      @(negedge clk) rst_n = 1'b1;
      dly = 0;
      frames(7);
      q.delete();
      add(7'h18, 1); add(7'h09, 1); add(7'h08, 1); add(7'h0A, 1);
      add(7'h08, 1); add(7'h0C, 1); add(7'h08, 1); add(7'h00, 1);
      trace("t6", 8'h3C, 8'h3C);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
